bin2bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
//   It converts an N_BITS binary value into two BCD digits (tens, units). Those digits

---
 rtl/bcd_pkg.sv | 7 +
 rtl/bin2bcd_seq_if.sv | 17 +
 rtl/bcd_add3.sv | 11 +
 rtl/bin2bcd_seq.sv | 103 ++++++++++
 tb/tb_bin2bcd_seq.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter and its display path.
package bcd_pkg;
  typedef logic [3:0] bcd_digit_t;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;
  localparam int BCD_MAX = 99;
  localparam bcd_digit_t BCD_NINE = 4'd9;
endpackage

// File: rtl/bin2bcd_seq_if.sv
// Start/busy/done handshake plus result digits between requester and bin2bcd_seq.
interface bin2bcd_seq_if
  import bcd_pkg::*;
#(
  parameter int N_BITS = 7
);
  logic              start;
  logic [N_BITS-1:0] bin;
  logic              busy;
  logic              done;
  bcd_digit_t        tens;
  bcd_digit_t        units;
  logic              ovf;

  modport master (output start, bin, input busy, done, tens, units, ovf);
  modport slave  (input start, bin, output busy, done, tens, units, ovf);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t d_i,
  output bcd_digit_t d_o
);
  always_comb begin
    d_o = (d_i >= 4'd5) ? bcd_digit_t'(d_i + 4'd3) : d_i;
  end
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter producing saturated tens/units digits.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int N_BITS = 7
)(
  input  logic           clk,
  input  logic           rst,
  bin2bcd_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(N_BITS + 1);

  b2b_state_t        state_q, state_d;
  logic [N_BITS-1:0] shreg_q, shreg_d;
  logic [11:0]       scr_q, scr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  bcd_digit_t        tens_q, tens_d;
  bcd_digit_t        units_q, units_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  bcd_digit_t        h_adj, t_adj, u_adj;

  bcd_add3 u_add3_h (.d_i(scr_q[11:8]), .d_o(h_adj));
  bcd_add3 u_add3_t (.d_i(scr_q[7:4]),  .d_o(t_adj));
  bcd_add3 u_add3_u (.d_i(scr_q[3:0]),  .d_o(u_adj));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      tens_q  <= '0;
      units_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      tens_q  <= tens_d;
      units_q <= units_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(N_BITS - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result digits are only written in DONE so the display never sees partial values.
  always_comb begin
    shreg_d = shreg_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    units_d = units_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d = bus.bin;
          scr_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        {scr_d, shreg_d} = {h_adj, t_adj, u_adj, shreg_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      DONE: begin
        done_d = 1'b1;
        if (scr_q[11:8] != 4'd0) begin
          tens_d  = BCD_NINE;
          units_d = BCD_NINE;
          ovf_d   = 1'b1;
        end else begin
          tens_d  = scr_q[7:4];
          units_d = scr_q[3:0];
          ovf_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = done_q;
    bus.tens  = tens_q;
    bus.units = units_q;
    bus.ovf   = ovf_q;
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq (N_BITS=7).
module tb_bin2bcd_seq;
  import bcd_pkg::*;

  localparam int NB = 7;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   lat;
  int   bcnt;
  int   ndone;
  int   early;
  int   cyc;
  int   last;
  bit   got;
  logic [3:0] cap_t, cap_u;
  logic [8:0] exp9;

  bin2bcd_seq_if #(.N_BITS(NB)) bus ();

  bin2bcd_seq #(.N_BITS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at #1 after an edge with the DUT idle; returns done latency in edges after accept.
  task automatic run_conv(input logic [NB-1:0] v, output int l, output int b);
    bus.bin   = v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    l = 0;
    b = bus.busy ? 1 : 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        l = k;
        break;
      end
      if (bus.busy) b++;
    end
    if (l == 0) check("conv_timeout", 0, 1);
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Test 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("reset_idle", {bus.busy, bus.done, bus.tens, bus.units, bus.ovf}, 0);
    end

    // Test 2: bin=57
    run_conv(7'd57, lat, bcnt);
    check("b57_latency", lat, 8);
    check("b57_busy_cycles", bcnt, 8);
    check("b57_tens", bus.tens, 5);
    check("b57_units", bus.units, 7);
    check("b57_ovf", bus.ovf, 0);
    check("b57_busy_at_done", bus.busy, 0);
    @(posedge clk); #1;
    check("b57_done_one_cycle", bus.done, 0);
    repeat (4) @(posedge clk);
    #1 check("b57_hold", {bus.tens, bus.units, bus.ovf}, {4'd5, 4'd7, 1'b0});

    // Test 4: start 42, ignored second start with 88 at cycle 3
    bus.bin   = 7'd42;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0; early = 0; lat = 0; cap_t = '0; cap_u = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        bus.bin   = 7'd88;
        bus.start = 1'b1;
      end
      if (c == 4) bus.start = 1'b0;
      @(posedge clk); #1;
      if (c == 5) check("b42_no_intermediate", {bus.tens, bus.units}, {4'd5, 4'd7});
      if (bus.done) begin
        ndone++;
        if (lat == 0) begin
          lat   = c;
          cap_t = bus.tens;
          cap_u = bus.units;
        end
      end
      if (!bus.busy && lat == 0 && c < 8) early = 1;
    end
    check("b42_done_count", ndone, 1);
    check("b42_latency", lat, 8);
    check("b42_busy_early_drop", early, 0);
    check("b42_tens", cap_t, 4);
    check("b42_units", cap_u, 2);

    // Test 3: boundaries
    run_conv(7'd0, lat, bcnt);
    check("b0_digits", {bus.tens, bus.units, bus.ovf}, {4'd0, 4'd0, 1'b0});
    run_conv(7'd99, lat, bcnt);
    check("b99_digits", {bus.tens, bus.units, bus.ovf}, {4'd9, 4'd9, 1'b0});
    run_conv(7'd100, lat, bcnt);
    check("b100_digits", {bus.tens, bus.units, bus.ovf}, {4'd9, 4'd9, 1'b1});
    run_conv(7'd127, lat, bcnt);
    check("b127_digits", {bus.tens, bus.units, bus.ovf}, {4'd9, 4'd9, 1'b1});

    // Test 5: reset in the middle of a conversion
    bus.bin   = 7'd73;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async_clear", {bus.busy, bus.done, bus.tens, bus.units, bus.ovf}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    check("rst_no_done", ndone, 0);
    check("rst_outputs_zero", {bus.tens, bus.units, bus.ovf}, 0);
    run_conv(7'd73, lat, bcnt);
    check("b73_after_rst", {bus.tens, bus.units, bus.ovf}, {4'd7, 4'd3, 1'b0});

    // Test 6: back-to-back sweep with start held high
    bus.bin   = 7'd0;
    bus.start = 1'b1;
    cyc  = 0;
    last = 0;
    for (int v = 0; v < 128; v++) begin
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(posedge clk); #1;
        cyc++;
        if (bus.done) got = 1'b1;
      end
      if (!got) begin
        check("sweep_timeout", 0, 1);
        break;
      end
      if (v > BCD_MAX) exp9 = {4'd9, 4'd9, 1'b1};
      else             exp9 = {4'(v / 10), 4'(v % 10), 1'b0};
      check($sformatf("sweep_%0d", v), {bus.tens, bus.units, bus.ovf}, exp9);
      if (v > 0) check($sformatf("sweep_period_%0d", v), cyc - last, NB + 2);
      last    = cyc;
      bus.bin = 7'(v + 1);
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
